// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: asserts all per-domain resets together and releases them
// one by one after a hold time, with a software reset handshake and a release hold-off.
module reset_release_sequencer #(
   parameter int p_num_stages  = 3,
   parameter int p_hold_cycles = 16,
   parameter int p_stage_gap   = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_hold_off,
   input  logic                    i_sw_reset_req,
   output logic                    o_sw_reset_ack,
   output logic [p_num_stages-1:0] o_stage_reset_n,
   output logic                    o_busy,
   output logic                    o_all_released
);

   localparam int p_cnt_max = (p_hold_cycles > p_stage_gap) ? p_hold_cycles : p_stage_gap;
   localparam int p_cnt_w   = $clog2(p_cnt_max + 1);
   localparam logic [p_cnt_w-1:0] p_hold_last = p_cnt_w'(p_hold_cycles - 1);
   localparam logic [p_cnt_w-1:0] p_gap_last  = p_cnt_w'(p_stage_gap - 1);
   localparam logic [p_cnt_w-1:0] p_cnt_one   = p_cnt_w'(1'b1);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [p_cnt_w-1:0]      cnt_q, cnt_d;
   logic [p_num_stages-1:0] stage_q, stage_d;
   logic                    busy_q, busy_d;
   logic                    all_q, all_d;
   logic                    ack_q, ack_d;
   logic                    req_q, req_d;

   logic [p_num_stages:0]   stage_ext_s;
   logic [p_num_stages-1:0] stage_next_s;
   logic                    accept_s;
   logic                    release_s;

   // Releasing a stage shifts a 1 in from bit 0, so stage k never leads stage k-1.
   assign stage_ext_s  = {stage_q, 1'b1};
   assign stage_next_s = stage_ext_s[p_num_stages-1:0];
   assign accept_s     = i_sw_reset_req & ~req_q;
   assign release_s    = ((state_q == S_HOLD) && (cnt_q == p_hold_last) && !i_hold_off) ||
                         ((state_q == S_RELEASE) && (cnt_q == p_gap_last));

   // Next-state, counter and output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      busy_d  = busy_q;
      all_d   = all_q;
      ack_d   = 1'b0;
      req_d   = i_sw_reset_req;
      if (accept_s) begin
         state_d = S_HOLD;
         cnt_d   = '0;
         stage_d = '0;
         busy_d  = 1'b1;
         all_d   = 1'b0;
         ack_d   = 1'b1;
      end else if (release_s) begin
         stage_d = stage_next_s;
         cnt_d   = '0;
         if (stage_next_s[p_num_stages-1]) begin
            state_d = S_RUN;
            busy_d  = 1'b0;
            all_d   = 1'b1;
         end else begin
            state_d = S_RELEASE;
         end
      end else begin
         case (state_q)
            S_HOLD: begin
               // Saturate at the last hold count while hold-off keeps us here.
               if (cnt_q != p_hold_last) begin
                  cnt_d = cnt_q + p_cnt_one;
               end else begin
                  cnt_d = cnt_q;
               end
            end
            S_RELEASE: begin
               cnt_d = cnt_q + p_cnt_one;
            end
            S_RUN: begin
               cnt_d = cnt_q;
            end
            default: begin
               state_d = S_HOLD;
               cnt_d   = '0;
               stage_d = '0;
               busy_d  = 1'b1;
               all_d   = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; a request held through reset is not accepted afterwards.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= S_HOLD;
         cnt_q   <= '0;
         stage_q <= '0;
         busy_q  <= 1'b1;
         all_q   <= 1'b0;
         ack_q   <= 1'b0;
         req_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         busy_q  <= busy_d;
         all_q   <= all_d;
         ack_q   <= ack_d;
         req_q   <= req_d;
      end
   end

   assign o_stage_reset_n = stage_q;
   assign o_busy          = busy_q;
   assign o_all_released  = all_q;
   assign o_sw_reset_ack  = ack_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer: expected output vectors are derived
// from release-edge formulas, queued per edge, and compared after each rising edge.
module tb_reset_release_sequencer;

   localparam int N = 3;
   localparam int H = 16;
   localparam int G = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         hold_off = 1'b0;
   logic         req = 1'b0;
   logic         ack;
   logic [N-1:0] stage;
   logic         busy;
   logic         all_rel;

   logic         reset1_n = 1'b0;
   logic         hold_off1 = 1'b0;
   logic         req1 = 1'b0;
   logic         ack1;
   logic [0:0]   stage1;
   logic         busy1;
   logic         all1;

   int errors = 0;
   int checks = 0;

   logic [5:0] sb_q[$];
   logic [3:0] sb1_q[$];

   always #5 clk = ~clk;

   reset_release_sequencer #(.p_num_stages(N), .p_hold_cycles(H), .p_stage_gap(G)) u_dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_hold_off(hold_off), .i_sw_reset_req(req),
      .o_sw_reset_ack(ack), .o_stage_reset_n(stage), .o_busy(busy), .o_all_released(all_rel)
   );

   reset_release_sequencer #(.p_num_stages(1), .p_hold_cycles(1), .p_stage_gap(1)) u_dut1 (
      .i_clk(clk), .i_reset_n(reset1_n), .i_hold_off(hold_off1), .i_sw_reset_req(req1),
      .o_sw_reset_ack(ack1), .o_stage_reset_n(stage1), .o_busy(busy1), .o_all_released(all1)
   );

   // Expected {stage, busy, all_released, ack} at edge e when stage 0 releases at t0.
   function automatic logic [5:0] exp_vec(int e, int t0, int ack_e);
      logic [2:0] s;
      s = 3'b000;
      for (int k = 0; k < N; k++) s[k] = (e >= t0 + k * G);
      return {s, (s != 3'b111), (s == 3'b111), (e == ack_e)};
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [5:0] exp_v;
      reset_n = 1'b0; hold_off = 1'b0; req = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         sb_q.push_back(exp_vec(e, 1000, -1));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL reset_hold edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
      reset_n = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         sb_q.push_back(exp_vec(e, H, -1));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL reset_release edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
   endtask

   task automatic test_hold_off();
      logic [5:0] exp_v;
      hold_off = 1'b1;
      do_reset();
      for (int e = 1; e <= 60; e++) begin
         hold_off = (e < 40);
         sb_q.push_back(exp_vec(e, 40, -1));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL hold_off edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
      hold_off = 1'b0;
   endtask

   task automatic test_sw_req_run();
      logic [5:0] exp_v;
      for (int e = 1; e <= 40; e++) begin
         req = (e <= 10);
         sb_q.push_back(exp_vec(e, 1 + H, 1));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL sw_req_run edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
      req = 1'b0;
   endtask

   task automatic test_req_mid_release();
      logic [5:0] exp_v;
      do_reset();
      for (int e = 1; e <= 62; e++) begin
         req = (e >= 26 && e <= 30);
         sb_q.push_back((e < 26) ? exp_vec(e, H, -1) : exp_vec(e, 26 + H, 26));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL req_mid_release edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
      req = 1'b0;
   endtask

   task automatic test_reset_over_req();
      logic [5:0] exp_v;
      do_reset();
      for (int e = 1; e <= 22; e++) begin
         if (e >= 20) begin
            reset_n = 1'b0;
            req = 1'b1;
         end
         sb_q.push_back((e < 20) ? exp_vec(e, H, -1) : exp_vec(e, 1000, -1));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL reset_over_req edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
      reset_n = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         sb_q.push_back(exp_vec(e, H, -1));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL req_held_after_reset edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp_v;
      for (int e = 1; e <= 40; e++) begin
         req = (e == 2) || (e >= 4);
         if (e == 1)     sb_q.push_back(exp_vec(e, -100, -1));
         else if (e < 4) sb_q.push_back(exp_vec(e, 2 + H, 2));
         else            sb_q.push_back(exp_vec(e, 4 + H, 4));
         @(posedge clk); #1;
         exp_v = sb_q.pop_front(); checks++;
         if ({stage, busy, all_rel, ack} !== exp_v) begin
            errors++;
            $display("FAIL back_to_back edge %0d: got %b expected %b", e, {stage, busy, all_rel, ack}, exp_v);
         end
      end
      req = 1'b0;
   endtask

   task automatic test_single_stage();
      logic [3:0] exp_v;
      reset1_n = 1'b0; req1 = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         if (e == 3) reset1_n = 1'b1;
         req1 = (e == 7) || (e == 8);
         if (e < 3)       sb1_q.push_back(4'b0100);
         else if (e == 7) sb1_q.push_back(4'b0101);
         else             sb1_q.push_back(4'b1010);
         @(posedge clk); #1;
         exp_v = sb1_q.pop_front(); checks++;
         if ({stage1, busy1, all1, ack1} !== exp_v) begin
            errors++;
            $display("FAIL single_stage edge %0d: got %b expected %b", e, {stage1, busy1, all1, ack1}, exp_v);
         end
      end
      req1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hold_off();
      test_sw_req_run();
      test_req_mid_release();
      test_reset_over_req();
      test_back_to_back();
      test_single_stage();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
